// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder with a loadable wrap-around position counter.
// Optional glitch filter on the synchronized phases: define QDEC_FILTER_EN.
module quadrature_decoder #(
  parameter int LENGTH     = 16,
  parameter int FILTER_LEN = 3
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_A,
  input  logic              i_B,
  input  logic              i_Load_Signal,
  input  logic [LENGTH-1:0] i_Load_Data,
  input  logic              i_Clear_Error,
  output logic [LENGTH-1:0] o_Position,
  output logic              o_Step,
  output logic              o_Direction,
  output logic              o_Error
);

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_filter_len_check
    $error("FILTER_LEN must be in 2..15");
  end

  // Phase pairs are packed {A, B}.
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic [1:0] warm_reg;
  logic       sync_ready;
  logic [1:0] ab;
  logic       ab_ready;

  // warm_reg keeps the decoder idle until the synchronizer holds real pin samples,
  // so levels present at reset release are captured as the initial state.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      meta_reg <= 2'b00;
      sync_reg <= 2'b00;
      warm_reg <= 2'd0;
    end else begin
      meta_reg <= {i_A, i_B};
      sync_reg <= meta_reg;
      if (warm_reg != 2'd2) warm_reg <= warm_reg + 2'd1;
    end
  end

  assign sync_ready = (warm_reg == 2'd2);

`ifdef QDEC_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic primed_reg;

  // The first valid synchronized sample seeds the accepted values directly.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) primed_reg <= 1'b0;
    else if (sync_ready) primed_reg <= 1'b1;
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_filt
    logic [CW-1:0] cnt_reg;
    logic          acc_reg;

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        cnt_reg <= '0;
        acc_reg <= 1'b0;
      end else if (!primed_reg) begin
        cnt_reg <= '0;
        if (sync_ready) acc_reg <= sync_reg[gi];
      end else if (sync_reg[gi] == acc_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        cnt_reg <= '0;
        acc_reg <= sync_reg[gi];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end

    assign ab[gi] = acc_reg;
  end

  assign ab_ready = primed_reg;
`else
  assign ab       = sync_reg;
  assign ab_ready = sync_ready;
`endif

  // Position of a phase pair along the forward cycle 00,01,11,10.
  function automatic logic [1:0] phase_index(input logic [1:0] v);
    case (v)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  logic [1:0]        ab_prev_reg;
  logic              init_reg;
  logic [1:0]        delta;
  logic              is_fwd;
  logic              is_rev;
  logic              is_bad;
  logic [LENGTH-1:0] position_reg;
  logic              step_reg;
  logic              direction_reg;
  logic              error_reg;

  assign delta  = phase_index(ab) - phase_index(ab_prev_reg);
  assign is_fwd = ab_ready && init_reg && (delta == 2'd1);
  assign is_rev = ab_ready && init_reg && (delta == 2'd3);
  assign is_bad = ab_ready && init_reg && (delta == 2'd2);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      ab_prev_reg   <= 2'b00;
      init_reg      <= 1'b0;
      position_reg  <= '0;
      step_reg      <= 1'b0;
      direction_reg <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      if (ab_ready) begin
        ab_prev_reg <= ab;
        init_reg    <= 1'b1;
      end
      step_reg <= is_fwd || is_rev;
      if (is_fwd || is_rev) direction_reg <= is_fwd;
      if (is_bad) error_reg <= 1'b1;
      else if (i_Clear_Error) error_reg <= 1'b0;
      if (i_Load_Signal) position_reg <= i_Load_Data;
      else if (is_fwd) position_reg <= position_reg + LENGTH'(1);
      else if (is_rev) position_reg <= position_reg - LENGTH'(1);
    end
  end

  assign o_Position  = position_reg;
  assign o_Step      = step_reg;
  assign o_Direction = direction_reg;
  assign o_Error     = error_reg;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder: directed plan plus a random walk
// checked every cycle against a pin-history reference model.
module tb_quadrature_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_data = 16'h0000;
  logic        clr = 1'b0;
  logic [15:0] o_position;
  logic        o_step;
  logic        o_direction;
  logic        o_error;

  quadrature_decoder #(.LENGTH(16), .FILTER_LEN(3)) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_A(a),
    .i_B(b),
    .i_Load_Signal(load),
    .i_Load_Data(load_data),
    .i_Clear_Error(clr),
    .o_Position(o_position),
    .o_Step(o_step),
    .o_Direction(o_direction),
    .o_Error(o_error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int step_count = 0;
  bit model_on = 1'b1;

  // Reference model: forward successor of each {A,B} level.
  logic [1:0]  fwd_next [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic [1:0]  pin_q[$];
  int          n_edges = 0;
  logic [15:0] m_pos = 16'h0000;
  logic        m_step = 1'b0;
  logic        m_dir = 1'b0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A pin level sampled at edge k is decoded against the one from k-1 at edge k+2;
  // the decoder starts comparing once three non-reset samples exist.
  task automatic model_update();
    logic [1:0] cur;
    logic [1:0] prv;
    logic fwd;
    logic rev;
    logic bad;
    if (rst) begin
      n_edges = 0;
      pin_q.delete();
      m_pos = 16'h0000;
      m_step = 1'b0;
      m_dir = 1'b0;
      m_err = 1'b0;
      return;
    end
    n_edges++;
    pin_q.push_back({a, b});
    if (pin_q.size() > 4) void'(pin_q.pop_front());
    fwd = 1'b0;
    rev = 1'b0;
    bad = 1'b0;
    if (n_edges >= 4) begin
      prv = pin_q[0];
      cur = pin_q[1];
      if (cur != prv) begin
        if (cur == fwd_next[prv]) fwd = 1'b1;
        else if (prv == fwd_next[cur]) rev = 1'b1;
        else bad = 1'b1;
      end
    end
    m_step = fwd | rev;
    if (fwd | rev) m_dir = fwd;
    if (bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (load) m_pos = load_data;
    else if (fwd) m_pos = m_pos + 16'd1;
    else if (rev) m_pos = m_pos - 16'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    if (o_step === 1'b1) step_count++;
    if (model_on) begin
      chk("position", 32'(o_position), 32'(m_pos));
      chk("step", 32'(o_step), 32'(m_step));
      chk("direction", 32'(o_direction), 32'(m_dir));
      chk("error", 32'(o_error), 32'(m_err));
    end
  endtask

  task automatic set_pins(input logic [1:0] v);
    a = v[1];
    b = v[0];
  endtask

  task automatic hold(input logic [1:0] v, input int cycles);
    set_pins(v);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    logic [1:0] pins;
    logic [1:0] fwd_seq [4];
    logic [1:0] rev_seq [4];
    int r;
    int h;
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
`ifdef QDEC_FILTER_EN
    model_on = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    hold(2'b00, 10);
    step_count = 0;
    // Two-cycle A glitch must be swallowed.
    hold(2'b10, 2);
    hold(2'b00, 10);
    chk("glitch_steps", 32'(step_count), 32'd0);
    chk("glitch_error", 32'(o_error), 32'd0);
    chk("glitch_position", 32'(o_position), 32'd0);
    // Stable forward change: step appears on the 6th edge counting the sample edge as 1.
    set_pins(2'b01);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("filt_step_e%0d", k), 32'(o_step), (k == 6) ? 32'd1 : 32'd0);
    end
    chk("filt_position", 32'(o_position), 32'd1);
    chk("filt_direction", 32'(o_direction), 32'd1);
    chk("filt_error", 32'(o_error), 32'd0);
`else
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    chk("reset_position", 32'(o_position), 32'd0);
    chk("reset_step", 32'(o_step), 32'd0);
    chk("reset_error", 32'(o_error), 32'd0);
    rst = 1'b0;
    hold(2'b00, 5);

    // Four forward cycles, 4 cycles per state.
    step_count = 0;
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 4; s++) hold(fwd_seq[s], 4);
    chk("fwd_steps", 32'(step_count), 32'd16);
    chk("fwd_position", 32'(o_position), 32'd16);
    chk("fwd_direction", 32'(o_direction), 32'd1);
    chk("fwd_error", 32'(o_error), 32'd0);

    // Load 2, then reverse through zero.
    load = 1'b1;
    load_data = 16'h0002;
    tick();
    load = 1'b0;
    hold(rev_seq[0], 4);
    chk("rev_pos1", 32'(o_position), 32'h0001);
    hold(rev_seq[1], 4);
    chk("rev_pos0", 32'(o_position), 32'h0000);
    hold(rev_seq[2], 4);
    chk("rev_wrap", 32'(o_position), 32'hFFFF);
    chk("rev_direction", 32'(o_direction), 32'd0);
    hold(2'b00, 4);

    // Illegal 00->11 jump.
    set_pins(2'b11);
    tick();
    tick();
    chk("err_not_yet", 32'(o_error), 32'd0);
    tick();
    chk("err_set", 32'(o_error), 32'd1);
    chk("err_position", 32'(o_position), 32'hFFFE);
    hold(2'b11, 1);
    hold(2'b01, 4);
    // Clear coinciding with a decoded 01->10 jump: set wins.
    set_pins(2'b10);
    tick();
    tick();
    clr = 1'b1;
    tick();
    chk("err_set_wins", 32'(o_error), 32'd1);
    tick();
    clr = 1'b0;
    chk("err_cleared", 32'(o_error), 32'd0);
    hold(2'b10, 2);
    hold(2'b00, 4);

    // Load in the same cycle a forward step is decoded.
    set_pins(2'b01);
    tick();
    tick();
    load = 1'b1;
    load_data = 16'h1234;
    tick();
    load = 1'b0;
    chk("load_pri_position", 32'(o_position), 32'h1234);
    chk("load_pri_step", 32'(o_step), 32'd1);
    chk("load_pri_direction", 32'(o_direction), 32'd1);
    hold(2'b01, 3);

    // Random walk with occasional loads, clears and illegal jumps.
    pins = 2'b01;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r < 9) pins = fwd_next[pins];
      else if (r < 18) begin
        for (int s = 0; s < 4; s++)
          if (fwd_next[s] == pins) begin
            pins = 2'(s);
            break;
          end
      end else if (r == 18) pins = ~pins;
      set_pins(pins);
      load = ($urandom_range(0, 15) == 0);
      load_data = 16'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      h = $urandom_range(1, 3);
      tick();
      load = 1'b0;
      clr = 1'b0;
      for (int j = 1; j < h; j++) tick();
    end
    hold(pins, 3);

    // Reset mid-sequence with both pins high.
    set_pins(2'b11);
    rst = 1'b1;
    tick();
    chk("midrst_position", 32'(o_position), 32'd0);
    chk("midrst_step", 32'(o_step), 32'd0);
    chk("midrst_direction", 32'(o_direction), 32'd0);
    chk("midrst_error", 32'(o_error), 32'd0);
    rst = 1'b0;
    step_count = 0;
    hold(2'b11, 8);
    chk("post_rst_steps", 32'(step_count), 32'd0);
    chk("post_rst_error", 32'(o_error), 32'd0);
    chk("post_rst_position", 32'(o_position), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Decodes a two-phase quadrature signal (A/B, e.g. from a rotary encoder) into a signed step stream and an up/down position count. It is the producer side of our bidirectional counting path: it derives direction and count-enable from the physical inputs, and maintains a loadable wrap-around position register. Asynchronous pins enter through an internal synchronizer. All outputs are registered in the `i_Clk` domain.

## Interface
- `LENGTH`, 16: width of the position register.
- `FILTER_LEN`, 3: consecutive stable samples required by the glitch filter; only used with `QDEC_FILTER_EN`; legal range 2..15.

Ports:
- `i_Clk`  in  1  system clock; all logic on its rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_A`  in  1  phase A, asynchronous to `i_Clk`.
- `i_B`  in  1  phase B, asynchronous to `i_Clk`.
- `i_Load_Signal`  in  1  when 1, `o_Position` is loaded with `i_Load_Data` on this edge.
- `i_Load_Data`  in  LENGTH  value to load.
- `i_Clear_Error`  in  1  clears `o_Error`.
- `o_Position`  out  LENGTH  current position.
- `o_Step`  out  1  one-cycle pulse per valid quadrature transition.
- `o_Direction`  out  1  1 = last valid step was forward, 0 = reverse.
- `o_Error`  out  1  sticky flag set on an illegal transition (both phases changed at once).

## Operation
- **Input path.** `i_A` and `i_B` each pass through a 2-flop synchronizer, giving `ab_sync`. Without the filter, the accepted value `ab` = `ab_sync`.
- **Decode.** The decoder compares `ab` with `ab_prev`, the last accepted value, and `ab_prev` <= `ab` every cycle.
  - Forward sequence: 00→01→11→10→00. Each such transition gives `o_Step`=1, `o_Direction`=1, position +1.
  - Reverse sequence: 00→10→11→01→00. Each gives `o_Step`=1, `o_Direction`=0, position −1.
  - No change: `o_Step`=0; position and `o_Direction` hold.
  - Both bits changed (00↔11, 01↔10): `o_Step`=0, `o_Error` <= 1, position and `o_Direction` hold, `ab_prev` still updates.
- **Init state.** After reset an internal `init` flag is clear. The first decode cycle only captures `ab_prev` and sets `init`. No step and no error are produced, whatever the pin levels are.
- **Arithmetic.** Position arithmetic is modulo 2^LENGTH.
  - Forward from all-ones wraps to 0.
  - Reverse from 0 wraps to all-ones.
  - No saturation and no overflow flag.
- **Load priority.** `i_Load_Signal`=1 has priority over a step in the same cycle.
  - `o_Position` <= `i_Load_Data`.
  - That step is discarded from the count, but `o_Step` and `o_Direction` still report it.
  - `ab_prev` updates normally.
- **Error flag.** `i_Clear_Error`=1 clears `o_Error`. If an illegal transition occurs in the same cycle, set wins and `o_Error` stays 1.
- **Reset values.** While `i_Reset`=1, all of the following are 0: `o_Position`, `o_Step`, `o_Direction`, `o_Error`, `init`, synchronizer flops, `ab_prev`, filter state. Reset has priority over load and clear. Asserting reset mid-sequence loses the count, and the first post-reset sample is treated as the init state.

## Timing
- **Latency, filter off.** A pin change sampled at edge N gives `o_Step`/`o_Position` updated at edge N+2, visible after it. This is 2 synchronizer stages plus 1 registered decode.
- **Latency, filter on.** Add FILTER_LEN edges.
- **Maximum rate.** One valid transition per decode cycle. Phase edges must be at least 1 cycle apart without the filter, and at least FILTER_LEN+1 cycles apart with it. Faster edges can alias to illegal transitions and raise `o_Error`.
- **Pulse width.** `o_Step` is exactly 1 cycle wide per transition. Back-to-back steps produce consecutive pulses.
- **Load timing.** The loaded value appears on `o_Position` the cycle after the load edge.

## Configuration
- `QDEC_FILTER_EN` defined: a glitch filter is inserted between `ab_sync` and the decoder.
  - Per phase, a counter counts consecutive edges on which the synchronized bit differs from its accepted value and equals its previous sample. Any break resets the counter to 0.
  - When the counter reaches FILTER_LEN, the accepted bit <= the synchronized bit.
  - Pulses shorter than FILTER_LEN cycles are rejected. Accepted values reset to 0.
- `QDEC_FILTER_EN` undefined: `ab` = `ab_sync`. No filter logic and no added latency; `FILTER_LEN` is ignored.

## Test plan
- Reset, then hold A=B=0 for 5 cycles, then drive 00→01→11→10→00 four times, 4 cycles per state → 16 `o_Step` pulses, `o_Direction`=1, `o_Position`=16, `o_Error`=0.
- Load 0x0002, then drive 3 reverse transitions → `o_Position` = 0x0001, 0x0000, 0xFFFF; `o_Direction`=0.
- Drive A,B 00→11 on one edge → `o_Error`=1 three edges later, position unchanged. Assert `i_Clear_Error` together with a new 01→10 jump → `o_Error` stays 1. Clear alone → 0.
- Assert `i_Load_Signal` (0x1234) in the same cycle a forward step is decoded → `o_Position`=0x1234, `o_Step`=1, `o_Direction`=1.
- Assert `i_Reset` for 1 cycle with A=B=1 mid-sequence → all outputs 0. Next cycles, with pins held at 11 → no step, no error.
- `QDEC_FILTER_EN`, FILTER_LEN=3: a 2-cycle A glitch → no step. A 3-cycle-stable change → one step, 5 edges after the first sample.
